// File: rtl/alu_pkg.sv
// Shared ALU decode types: control codes, decode result and funct7 patterns.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e alu_ctrl;
        logic      is_shamt;
        logic      is_muldiv;
        logic      illegal;
    } alu_dec_t;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Decode of "no ALU class": plain ADD, no flags.
    localparam alu_dec_t ALU_DEC_NOP = '{alu_ctrl: ALU_ADD, is_shamt: 1'b0,
                                         is_muldiv: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/alu_decode_pipe_if.sv
// Decode-request / decoded-result bus between decode stage and execute stage.
interface alu_decode_pipe_if #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             instr_5;
    logic             isBranch;
    logic             isALUreg;
    logic             isALUimm;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_ctrl;
    logic             is_shamt;
    logic             is_muldiv;
    logic             illegal;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] illegal_cnt;

    // Requester / consumer side
    modport master (
        output in_valid, funct3, funct7, instr_5, isBranch, isALUreg, isALUimm, out_ready,
        input  in_ready, out_valid, alu_ctrl, is_shamt, is_muldiv, illegal, count, illegal_cnt
    );

    // Decoder queue side
    modport slave (
        input  in_valid, funct3, funct7, instr_5, isBranch, isALUreg, isALUimm, out_ready,
        output in_ready, out_valid, alu_ctrl, is_shamt, is_muldiv, illegal, count, illegal_cnt
    );

endinterface

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I(+M) ALU decoder: instruction fields in, decode struct out.
module alu_decode_comb
    import alu_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       instr_5,
    input  logic       isBranch,
    input  logic       isALUreg,
    input  logic       isALUimm,
    output alu_dec_t   dec
);

    logic      f7_base;
    logic      f7_alt;
    logic      f7_md;
    alu_ctrl_e rr_op;

    assign f7_base = (funct7 == FUNCT7_BASE);
    assign f7_alt  = (funct7 == FUNCT7_ALT);
    assign f7_md   = (funct7 == FUNCT7_MULDIV);

    // Arithmetic op shared by reg and imm forms; SUB only exists in the reg form
    always_comb begin
        rr_op = ALU_ADD;
        unique case (funct3)
            3'b000: rr_op = (isALUreg && instr_5 && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: rr_op = ALU_SLL;
            3'b010: rr_op = ALU_SLT;
            3'b011: rr_op = ALU_SLTU;
            3'b100: rr_op = ALU_XOR;
            3'b101: rr_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: rr_op = ALU_OR;
            3'b111: rr_op = ALU_AND;
            default: rr_op = ALU_ADD;
        endcase
    end

    // Class-specific decode and legality; illegal encodings fall back to ADD with no other flags
    always_comb begin
        dec = ALU_DEC_NOP;
        if (isBranch) begin
            unique case (funct3[2:1])
                2'b00:   dec.alu_ctrl = ALU_SUB;
                2'b10:   dec.alu_ctrl = ALU_SLT;
                2'b11:   dec.alu_ctrl = ALU_SLTU;
                default: dec.illegal  = 1'b1;
            endcase
        end else if (isALUreg) begin
            if (f7_md) begin
                if (ENABLE_M) begin
                    dec.is_muldiv = 1'b1;
                    dec.alu_ctrl  = alu_ctrl_e'({1'b0, funct3});
                end else begin
                    dec.illegal = 1'b1;
                end
            end else if (f7_base || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                dec.alu_ctrl = rr_op;
            end else begin
                dec.illegal = 1'b1;
            end
        end else if (isALUimm) begin
            // funct7 is immediate data except for the shift forms
            if (funct3 == 3'b001) begin
                if (f7_base) begin
                    dec.alu_ctrl = rr_op;
                    dec.is_shamt = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end else if (funct3 == 3'b101) begin
                if (f7_base || f7_alt) begin
                    dec.alu_ctrl = rr_op;
                    dec.is_shamt = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end else begin
                dec.alu_ctrl = rr_op;
            end
        end
    end

endmodule

// File: rtl/alu_decode_pipe.sv
// ALU decoder followed by a DEPTH-entry valid/ready queue toward execute.
module alu_decode_pipe
    import alu_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_decode_pipe_if.slave  bus
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    alu_dec_t         dec;
    alu_dec_t         mem [DEPTH];
    alu_dec_t         head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] ill_cnt;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    alu_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
        .funct3   (bus.funct3),
        .funct7   (bus.funct7),
        .instr_5  (bus.instr_5),
        .isBranch (bus.isBranch),
        .isALUreg (bus.isALUreg),
        .isALUimm (bus.isALUimm),
        .dec      (dec)
    );

    // in_ready depends only on stored occupancy, so a pop never frees a slot in the same cycle
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = bus.in_valid & in_ready & ~flush;
    assign pop       = out_valid & bus.out_ready & ~flush;

    // Pointers and occupancy; flush empties the queue and discards any coincident handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; slots outside the live window are never visible, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Saturating count of accepted illegal encodings; survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (push && dec.illegal && (ill_cnt != '1)) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

    assign head = mem[rd_ptr];

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.alu_ctrl    = out_valid ? head.alu_ctrl  : 4'b0000;
    assign bus.is_shamt    = out_valid ? head.is_shamt  : 1'b0;
    assign bus.is_muldiv   = out_valid ? head.is_muldiv : 1'b0;
    assign bus.illegal     = out_valid ? head.illegal   : 1'b0;
    assign bus.count       = count;
    assign bus.illegal_cnt = ill_cnt;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Bench for alu_decode_pipe: three instances (DEPTH=2/M off, DEPTH=2/M on, DEPTH=3/M off)
// share one stimulus stream; each has its own scoreboard queue.
module tb_alu_decode_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       instr_5;
    logic       isBranch, isALUreg, isALUimm;

    int errors = 0;
    int checks = 0;

    logic [6:0] qa[$];
    logic [6:0] qb[$];
    logic [6:0] qc[$];

    always #5 clk = ~clk;

    alu_decode_pipe_if #(.DEPTH(2), .CNT_W(8)) if_a ();
    alu_decode_pipe_if #(.DEPTH(2), .CNT_W(8)) if_b ();
    alu_decode_pipe_if #(.DEPTH(3), .CNT_W(8)) if_c ();

    assign if_a.in_valid = in_valid;  assign if_b.in_valid = in_valid;  assign if_c.in_valid = in_valid;
    assign if_a.out_ready = out_ready; assign if_b.out_ready = out_ready; assign if_c.out_ready = out_ready;
    assign if_a.funct3 = funct3;      assign if_b.funct3 = funct3;      assign if_c.funct3 = funct3;
    assign if_a.funct7 = funct7;      assign if_b.funct7 = funct7;      assign if_c.funct7 = funct7;
    assign if_a.instr_5 = instr_5;    assign if_b.instr_5 = instr_5;    assign if_c.instr_5 = instr_5;
    assign if_a.isBranch = isBranch;  assign if_b.isBranch = isBranch;  assign if_c.isBranch = isBranch;
    assign if_a.isALUreg = isALUreg;  assign if_b.isALUreg = isALUreg;  assign if_c.isALUreg = isALUreg;
    assign if_a.isALUimm = isALUimm;  assign if_b.isALUimm = isALUimm;  assign if_c.isALUimm = isALUimm;

    alu_decode_pipe #(.DEPTH(2), .ENABLE_M(1'b0), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_a.slave));
    alu_decode_pipe #(.DEPTH(2), .ENABLE_M(1'b1), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_b.slave));
    alu_decode_pipe #(.DEPTH(3), .ENABLE_M(1'b0), .CNT_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_c.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode returning {alu_ctrl, is_shamt, is_muldiv, illegal}
    function automatic logic [3:0] arith(input logic [2:0] f3, input logic sub, input logic alt);
        case (f3)
            3'd0: return sub ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return alt ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [6:0] model(input logic br, input logic rg, input logic im,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic i5, input logic em);
        logic [3:0] c;
        logic sh, md, il;
        c = 4'd0; sh = 1'b0; md = 1'b0; il = 1'b0;
        if (br) begin
            case (f3)
                3'd0, 3'd1: c = 4'd1;
                3'd4, 3'd5: c = 4'd5;
                3'd6, 3'd7: c = 4'd6;
                default:    il = 1'b1;
            endcase
        end else if (rg) begin
            if (f7 == 7'h01) begin
                if (em) begin md = 1'b1; c = {1'b0, f3}; end
                else il = 1'b1;
            end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                c = arith(f3, i5 & f7[5], f7[5]);
            end else begin
                il = 1'b1;
            end
        end else if (im) begin
            if (f3 == 3'd1 && f7 != 7'h00) il = 1'b1;
            else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) il = 1'b1;
            else begin
                c  = arith(f3, 1'b0, f7[5]);
                sh = (f3 == 3'd1 || f3 == 3'd5);
            end
        end
        if (il) begin c = 4'd0; sh = 1'b0; md = 1'b0; end
        return {c, sh, md, il};
    endfunction

    // Scoreboard A: record accepted requests, compare head on each pop, payload zero when idle
    always @(negedge clk) begin
        logic [6:0] e;
        if (!rst_n || flush) qa.delete();
        else begin
            if (if_a.out_valid && out_ready) begin
                if (qa.size() == 0) chk("a_spurious_pop", if_a.out_valid, 1'b0);
                else begin
                    e = qa.pop_front();
                    chk("a_head", {if_a.alu_ctrl, if_a.is_shamt, if_a.is_muldiv, if_a.illegal}, e);
                end
            end
            if (!if_a.out_valid)
                chk("a_idle_zero", {if_a.alu_ctrl, if_a.is_shamt, if_a.is_muldiv, if_a.illegal}, 0);
            if (in_valid && if_a.in_ready)
                qa.push_back(model(isBranch, isALUreg, isALUimm, funct3, funct7, instr_5, 1'b0));
        end
    end

    // Scoreboard B (RV32M decode enabled)
    always @(negedge clk) begin
        logic [6:0] e;
        if (!rst_n || flush) qb.delete();
        else begin
            if (if_b.out_valid && out_ready) begin
                if (qb.size() == 0) chk("b_spurious_pop", if_b.out_valid, 1'b0);
                else begin
                    e = qb.pop_front();
                    chk("b_head", {if_b.alu_ctrl, if_b.is_shamt, if_b.is_muldiv, if_b.illegal}, e);
                end
            end
            if (in_valid && if_b.in_ready)
                qb.push_back(model(isBranch, isALUreg, isALUimm, funct3, funct7, instr_5, 1'b1));
        end
    end

    // Scoreboard C (DEPTH=3, exercises non-power-of-two wrap)
    always @(negedge clk) begin
        logic [6:0] e;
        if (!rst_n || flush) qc.delete();
        else begin
            if (if_c.out_valid && out_ready) begin
                if (qc.size() == 0) chk("c_spurious_pop", if_c.out_valid, 1'b0);
                else begin
                    e = qc.pop_front();
                    chk("c_head", {if_c.alu_ctrl, if_c.is_shamt, if_c.is_muldiv, if_c.illegal}, e);
                end
            end
            if (in_valid && if_c.in_ready)
                qc.push_back(model(isBranch, isALUreg, isALUimm, funct3, funct7, instr_5, 1'b0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input int cls, input logic [2:0] f3,
                          input logic [6:0] f7, input logic i5);
        in_valid = v;
        isBranch = (cls == 0);
        isALUreg = (cls == 1);
        isALUimm = (cls == 2);
        funct3   = f3;
        funct7   = f7;
        instr_5  = i5;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [6:0] f7tab [4];
        int acc;
        f7tab[0] = 7'h00; f7tab[1] = 7'h20; f7tab[2] = 7'h01; f7tab[3] = 7'h7f;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_count", if_a.count, 0);
        chk("rst_out_valid", if_a.out_valid, 0);
        chk("rst_in_ready", if_a.in_ready, 1);
        chk("rst_payload", {if_a.alu_ctrl, if_a.is_shamt, if_a.is_muldiv, if_a.illegal}, 0);
        chk("rst_illegal_cnt", if_a.illegal_cnt, 0);
        #1 rst_n = 1'b1;
        step();

        // Full sweep: 4 class settings x 8 funct3 x 4 funct7 patterns, streaming
        for (int cls = 0; cls < 4; cls++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int k = 0; k < 4; k++) begin
                    set_in(1'b1, cls, 3'(f3),
                           (k == 3) ? 7'($urandom_range(0, 127)) : f7tab[k],
                           1'($urandom_range(0, 1)));
                    step();
                end
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        step(); step();

        // Latency: SRAI accepted into empty queue is visible right after that edge
        set_in(1'b1, 2, 3'd5, 7'h20, 1'b0);
        step();
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        chk("lat_out_valid", if_a.out_valid, 1);
        chk("lat_alu_ctrl", if_a.alu_ctrl, 4'b1001);
        chk("lat_is_shamt", if_a.is_shamt, 1);
        step(); step();

        // RV32M: illegal without M, DIV-class decode with M
        do_reset();
        set_in(1'b1, 1, 3'd4, 7'h01, 1'b1);
        step();
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        chk("m0_illegal", if_a.illegal, 1);
        chk("m0_alu_ctrl", if_a.alu_ctrl, 4'b0000);
        chk("m0_illegal_cnt", if_a.illegal_cnt, 1);
        chk("m1_is_muldiv", if_b.is_muldiv, 1);
        chk("m1_alu_ctrl", if_b.alu_ctrl, 4'b0100);
        chk("m1_illegal_cnt", if_b.illegal_cnt, 0);
        step(); step();

        // Backpressure: three offered entries into DEPTH=2 with out_ready low
        out_ready = 1'b0;
        set_in(1'b1, 1, 3'd2, 7'h00, 1'b1); step();   // SLT
        set_in(1'b1, 1, 3'd4, 7'h00, 1'b1); step();   // XOR
        chk("bp_count_full", if_a.count, 2);
        chk("bp_in_ready_low", if_a.in_ready, 0);
        set_in(1'b1, 1, 3'd6, 7'h00, 1'b1); step();   // OR, must wait
        chk("bp_count_hold", if_a.count, 2);
        chk("bp_head_first", if_a.alu_ctrl, 4'b0101);
        out_ready = 1'b1;
        step();
        chk("bp_pop_no_push", if_a.count, 1);
        chk("bp_head_second", if_a.alu_ctrl, 4'b0100);
        step();
        chk("bp_push_pop", if_a.count, 1);
        chk("bp_head_third", if_a.alu_ctrl, 4'b0011);
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        step();
        chk("bp_drained", if_a.count, 0);

        // Flush with a full queue and a coincident push
        out_ready = 1'b0;
        set_in(1'b1, 1, 3'd7, 7'h00, 1'b0); step();
        set_in(1'b1, 1, 3'd1, 7'h00, 1'b0); step();
        chk("fl_full", if_a.count, 2);
        set_in(1'b1, 0, 3'd0, 7'h00, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        chk("fl_count", if_a.count, 0);
        chk("fl_out_valid", if_a.out_valid, 0);
        chk("fl_in_ready", if_a.in_ready, 1);
        chk("fl_c_count", if_c.count, 0);
        step(); step();
        chk("fl_no_ghost", if_c.out_valid, 0);

        // Async reset with one entry held
        out_ready = 1'b0;
        set_in(1'b1, 2, 3'd4, 7'h00, 1'b0); step();   // XORI
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        chk("ar_count_before", if_a.count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", if_a.count, 0);
        chk("ar_out_valid", if_a.out_valid, 0);
        chk("ar_payload", {if_a.alu_ctrl, if_a.is_shamt, if_a.is_muldiv, if_a.illegal}, 0);
        chk("ar_in_ready", if_a.in_ready, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Illegal counter saturation
        set_in(1'b1, 1, 3'd3, 7'h7f, 1'b0);
        repeat (200) step();
        chk("sat_mid", if_a.illegal_cnt, 200);
        repeat (100) step();
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        step();
        chk("sat_a", if_a.illegal_cnt, 255);
        chk("sat_b", if_b.illegal_cnt, 255);
        chk("sat_c", if_c.illegal_cnt, 255);

        // DEPTH=3 wrap: 10 accepted entries with random backpressure
        acc = 0;
        for (int i = 0; i < 80 && acc < 10; i++) begin
            set_in(1'b1, int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   f7tab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            if (if_c.in_ready) acc++;
            step();
        end
        chk("wrap_accepted", acc, 10);
        set_in(1'b0, 3, 3'd0, 7'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && if_c.count != 0; i++) step();
        chk("wrap_c_empty", if_c.count, 0);
        step();
        chk("sb_a_empty", qa.size(), 0);
        chk("sb_b_empty", qb.size(), 0);
        chk("sb_c_empty", qc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_decode_pipe.md
# alu_decode_pipe

Elastic, parametrised successor to the single-cycle ALU decoder, used in the pipelined RV32 core. It decodes funct3/funct7/opcode-class bits into a 4-bit ALU control code plus shift-amount, mul/div and illegal flags. Results are buffered in a DEPTH-entry valid/ready queue between decode and execute. It supports pipeline flush and optional RV32M decode, and counts illegal ALU encodings.

## Interface
- DEPTH, 2, queue entries (1..8)
- ENABLE_M, 0, 1 = decode funct7=0000001 as RV32M (is_muldiv), 0 = treat as illegal
- CNT_W, 8, width of saturating illegal-instruction counter

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous queue clear
- in_valid  in  1  decode request
- in_ready  out  1  queue can accept
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- instr_5  in  1  instr[5] (reg vs imm opcode bit)
- isBranch, isALUreg, isALUimm  in  1 each  opcode class, at most one high
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- alu_ctrl  out  4  ALU operation code
- is_shamt  out  1  immediate shift (use shamt field)
- is_muldiv  out  1  RV32M op; alu_ctrl = {1'b0, funct3}
- illegal  out  1  unsupported ALU encoding
- count  out  $clog2(DEPTH+1)  occupancy
- illegal_cnt  out  CNT_W  saturating count of accepted illegal entries

## Operation
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- isBranch: funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> ADD + illegal.
- isALUreg: 000 -> SUB if instr_5 & funct7[5] else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7[5] else SRL; 110 OR; 111 AND.
- isALUreg legality: funct7 must be 0000000, or 0100000 with funct3 000/101; else illegal.
- isALUreg with funct7 = 0000001: if ENABLE_M, is_muldiv=1 and alu_ctrl={0,funct3}; otherwise illegal.
- isALUimm: as isALUreg except 000 always ADD. 001/101 set is_shamt=1.
- isALUimm shift legality: 001 needs funct7=0000000; 101 needs 0000000/0100000; else illegal.
- No class bit set: ADD, all flags 0.
- Illegal entries are still queued, with alu_ctrl=ADD and the illegal flag set; execute traps.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- Outputs reflect the head entry. When out_valid=0, payload outputs are 0.
- illegal_cnt increments on each push with illegal=1 and saturates at all-ones. flush does not clear it.

## Timing
- Reset: count=0, out_valid=0, in_ready=1, alu_ctrl=0, is_shamt=is_muldiv=illegal=0, illegal_cnt=0. Pointers are 0.
- Latency: a push at edge N into an empty queue gives out_valid=1 after edge N.
- Throughput: 1 entry/cycle when out_ready is held high.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged.
- When full, in_ready=0. A pop at the same edge does not enable a same-cycle push; throughput drops only at full.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- flush: at that edge count=0 and pointers=0. A coincident push is dropped and a coincident pop is ignored. in_ready=1 the next cycle.
- rst_n deasserted mid-operation: all entries are lost immediately (async). Reset release is synchronised externally.

## Structure
- alu_pkg holds:
  - alu_ctrl_e enum with the codes above
  - decode result struct {alu_ctrl, is_shamt, is_muldiv, illegal}
  - FUNCT7_BASE/ALT/MULDIV constants
- Sub-module alu_decode_comb is purely combinational: fields in, result struct out. ENABLE_M is a parameter. It is reused by the single-cycle core.
- alu_decode_pipe contains alu_decode_comb, the DEPTH-entry struct array, pointers, count and the illegal counter.

## Test plan
- Reset then full decode sweep, DEPTH=2, out_ready=1. Example: isALUimm, funct3=101, funct7=0100000 -> SRA 1001, is_shamt=1 one cycle after accept. All 8 funct3 × 3 classes are compared against a model.
- Backpressure: out_ready=0, push 3 entries at DEPTH=2 -> in_ready=0 after 2 and count=2. Release -> entries pop in order; third accepted afterwards.
- ENABLE_M=0 vs 1: isALUreg, funct7=0000001, funct3=100. With 0 -> illegal=1 and illegal_cnt=1. With 1 -> is_muldiv=1, alu_ctrl=0100.
- Flush with count=2 coincident with in_valid=1 -> next cycle count=0, out_valid=0, dropped entry never appears.
- Async reset mid-stream with count=1 -> outputs zero before the next clock edge. illegal_cnt saturates at 255 after 300 illegal pushes (CNT_W=8).
- DEPTH=3 wrap: 10 push/pop pairs with random out_ready -> order preserved, no loss or duplication.
